// File: rtl/color_pkg.sv
// Shared types for the colour sequencer: RGB payload, FSM states, palette and fade step helper.
package color_pkg;

    localparam int unsigned CHAN_W = 8;
    localparam int unsigned PALETTE_DEPTH = 8;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FADE
    } state_t;

    localparam rgb_t PALETTE [PALETTE_DEPTH] = '{
        rgb_t'(24'hFF0000),
        rgb_t'(24'hFF8000),
        rgb_t'(24'hFFFF00),
        rgb_t'(24'h00FF00),
        rgb_t'(24'h00FFFF),
        rgb_t'(24'h0000FF),
        rgb_t'(24'hFF00FF),
        rgb_t'(24'hFFFFFF)
    };

    // One LSB toward the goal; saturates at the goal so it can never wrap.
    function automatic logic [CHAN_W-1:0] stepChan(input logic [CHAN_W-1:0] value,
                                                   input logic [CHAN_W-1:0] goal);
        if (value < goal) begin
            return value + CHAN_W'(1);
        end else if (value > goal) begin
            return value - CHAN_W'(1);
        end
        return value;
    endfunction

    function automatic rgb_t stepToward(input rgb_t value, input rgb_t goal);
        rgb_t res;
        res.r = stepChan(value.r, goal.r);
        res.g = stepChan(value.g, goal.g);
        res.b = stepChan(value.b, goal.b);
        return res;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Three-channel 8-bit PWM: prescaler, shared period counter and per-channel comparators.
module pwm_gen import color_pkg::*; #(
    parameter int unsigned PWM_DIV = 390
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  rgb_t duty,
    output logic led_r,
    output logic led_g,
    output logic led_b,
    output logic pwmWrap_c
);

    localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);

    logic [PRE_W-1:0]  prescaler;
    logic [CHAN_W-1:0] pwmCnt;
    logic              preWrap;

    assign preWrap   = (prescaler == PRE_MAX);
    assign pwmWrap_c = preWrap && (pwmCnt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            pwmCnt    <= '0;
            led_r     <= 1'b0;
            led_g     <= 1'b0;
            led_b     <= 1'b0;
        end else begin
            prescaler <= preWrap ? '0 : prescaler + PRE_W'(1);
            if (preWrap) begin
                pwmCnt <= pwmCnt + CHAN_W'(1);
            end
            led_r <= active && (pwmCnt < duty.r);
            led_g <= active && (pwmCnt < duty.g);
            led_b <= active && (pwmCnt < duty.b);
        end
    end

endmodule

// File: rtl/color_sequencer.sv
// Steps an RGB LED through the palette on each rising edge of secTick, with optional linear fade.
module color_sequencer import color_pkg::*; #(
    parameter int unsigned PWM_DIV    = 390,
    parameter int unsigned FADE_DIV   = 4,
    parameter int unsigned NUM_COLORS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       secTick,
    input  logic       enable,
    input  logic       fade_en,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [2:0] color_idx,
    output logic       busy
);

    localparam int unsigned FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    state_t            state, stateNext;
    rgb_t              cur, curNext, target, stepped;
    logic [2:0]        idxNext, idxInc;
    logic [FADE_W-1:0] fadeCnt, fadeCntNext;
    logic              tickD, tick, busyNext, ledActive, pwmWrap;

    assign tick    = secTick & ~tickD;
    assign target  = PALETTE[color_idx];
    assign idxInc  = (color_idx == 3'(NUM_COLORS - 1)) ? 3'd0 : color_idx + 3'd1;
    assign stepped = stepToward(cur, target);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            color_idx <= '0;
            cur       <= '0;
            fadeCnt   <= '0;
            busy      <= 1'b0;
            tickD     <= 1'b0;
        end else begin
            state     <= stateNext;
            color_idx <= idxNext;
            cur       <= curNext;
            fadeCnt   <= fadeCntNext;
            busy      <= busyNext;
            tickD     <= secTick;
        end
    end

    always_comb begin
        stateNext   = state;
        idxNext     = color_idx;
        curNext     = cur;
        fadeCntNext = fadeCnt;
        if (!enable) begin
            stateNext   = IDLE;
            curNext     = '0;
            fadeCntNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    stateNext = HOLD;
                    curNext   = target;
                end
                HOLD: begin
                    if (tick) begin
                        idxNext     = idxInc;
                        fadeCntNext = '0;
                        if (fade_en) begin
                            stateNext = FADE;
                        end else begin
                            curNext = PALETTE[idxInc];
                        end
                    end
                end
                FADE: begin
                    // Fade abandoned: land on the target, honouring a coincident tick as a hard step.
                    if (!fade_en) begin
                        stateNext = HOLD;
                        idxNext   = tick ? idxInc : color_idx;
                        curNext   = tick ? PALETTE[idxInc] : target;
                    end else if (tick) begin
                        idxNext     = idxInc;
                        curNext     = target;
                        fadeCntNext = '0;
                    end else if (cur == target) begin
                        stateNext = HOLD;
                    end else if (pwmWrap) begin
                        if (fadeCnt == FADE_W'(FADE_DIV - 1)) begin
                            fadeCntNext = '0;
                            curNext     = stepped;
                            if (stepped == target) begin
                                stateNext = HOLD;
                            end
                        end else begin
                            fadeCntNext = fadeCnt + FADE_W'(1);
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                    curNext   = '0;
                end
            endcase
        end
        busyNext  = (stateNext == FADE);
        ledActive = (stateNext != IDLE);
    end

    pwm_gen #(
        .PWM_DIV(PWM_DIV)
    ) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .active   (ledActive),
        .duty     (curNext),
        .led_r    (led_r),
        .led_g    (led_g),
        .led_b    (led_b),
        .pwmWrap_c(pwmWrap)
    );

endmodule
